wd_writeback_arbiter: RTL and testbench
=======================================

Name: wd_writeback_arbiter

Overview:
- Schedules the register-file write port among the six write-data sources feeding Mux_WD.
- Sources are indexed 0..5, identical to the Mux_WD selector codes.
- Each source raises a request with a destination register. The block grants one source per cycle round-robin and drives the Mux_WD selector, RegWrite and WriteReg.
- Sits between the datapath source units (ALU, memory, shifter, HI, LO, LUI) and the Banco_reg write port.

Parameters:
- N_SRC, 6, number of requesting sources; must equal the number of Mux_WD data inputs.
- SEL_W, 3, Mux_WD selector width.
- REG_W, 5, register-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  control-unit freeze; no new grant while high.
- req  in  N_SRC  per-source write request, level; held until granted.
- req_reg  in  N_SRC*REG_W  destination register per source; source i uses bits [i*REG_W +: REG_W].
- gnt  out  N_SRC  one-hot grant, registered, high for exactly one cycle per grant.
- wd_sel  out  SEL_W  Mux_WD selector, registered.
- reg_write  out  1  register-file write enable, registered.
- write_reg  out  REG_W  register-file write address, registered.
- busy  out  1  combinational; high when any unmasked request is pending or a grant is in flight.

Behaviour:
- Reset (async assert, sync release): gnt=0, wd_sel=0, reg_write=0, write_reg=0, rr_ptr=0, state=IDLE.
- Round-robin pointer rr_ptr (0..N_SRC-1) marks the highest-priority source. Search order is rr_ptr, rr_ptr+1, … with wrap modulo N_SRC; the pointer never takes values ≥ N_SRC.
- Eligible set = req & ~gnt. The source granted in the current cycle is masked, because its req is still high during its gnt cycle.
- Latency: a request sampled at edge t produces gnt/wd_sel/reg_write/write_reg valid for cycle t→t+1. The register file writes at edge t+1.
- Source handshake:
  - Data and req_reg are held stable through the gnt cycle.
  - req may deassert on the edge ending gnt.
  - If req is still high the cycle after gnt, it is a new request.
- On a grant to source k: rr_ptr ← (k+1) mod N_SRC.
- FSM states: IDLE, GRANT, HOLD.
  - IDLE: no eligible request. Outputs gnt=0, reg_write=0; wd_sel and write_reg hold their last values.
  - IDLE→GRANT: eligible request present and stall=0.
  - GRANT→GRANT: another eligible request present and stall=0. Back-to-back grants, one per cycle.
  - GRANT→IDLE: no eligible request.
  - Any state→HOLD: stall=1. In HOLD, gnt=0 and reg_write=0; rr_ptr and pending requests are frozen.
  - HOLD→GRANT/IDLE: stall=0, next edge, same arbitration as from IDLE.
- Stall precedence: stall=1 on the same edge as a new request means no grant. The request is served after stall drops.
- Register $0: a grant whose req_reg=0 still pulses gnt and updates wd_sel, but forces reg_write=0 and write_reg=0. The source is released.
- wd_sel is always 0..N_SRC-1; codes 6 and 7 are never driven.
- Reset mid-grant clears gnt and reg_write immediately (asynchronous). No partial write occurs after reset assertion.
- busy = (|(req & ~gnt)) | (|gnt).

Decomposition:
- Shared package holds: N_SRC, SEL_W, REG_W, source-index constants (SRC_ALU=0, SRC_MEM=1, SRC_SHIFT=2, SRC_HI=3, SRC_LO=4, SRC_LUI=5), and the FSM state encoding (IDLE=2'd0, GRANT=2'd1, HOLD=2'd2).
- One sub-module, rr_pick: combinational rotate → priority-encode → unrotate. Inputs are the eligible vector and rr_ptr; outputs are a one-hot vector and an index. The top module owns the FSM and output registers.

Test Plan:
- Reset: hold reset=0 with req=6'h3F → gnt=0, reg_write=0, wd_sel=0. Release → first grant is source 0 on the next edge.
- Single request: req=6'b000100, req_reg[2]=5'd9 → next cycle gnt=6'b000100, wd_sel=3'd2, reg_write=1, write_reg=9. After req drops: IDLE, busy=0.
- Fairness: req=6'h3F held continuously, each source dropping req after its gnt → grant order 0,1,2,3,4,5 in six consecutive cycles, with no gap cycles.
- Wrap-around: after a grant to source 4, raise req=6'b100011 → order 5, 0, 1.
- Stall: a pending req=6'b001000 while stall=1 for 3 cycles → gnt=0 and reg_write=0 throughout. Drop stall → gnt=6'b001000, wd_sel=3 one cycle later.
- Register $0 and async reset: req_reg[1]=0 → gnt=6'b000010 with reg_write=0. Assert reset mid-GRANT → gnt and reg_write go 0 before the next clk edge.

Source files
------------

// File: rtl/wd_writeback_arbiter_pkg.sv
// wd_writeback_arbiter_pkg: shared widths, source codes and FSM encoding for the write-back arbiter
package wd_writeback_arbiter_pkg;
   localparam int N_SRC = 6;
   localparam int SEL_W = 3;
   localparam int REG_W = 5;
   localparam logic [SEL_W-1:0] SRC_ALU   = 3'd0;
   localparam logic [SEL_W-1:0] SRC_MEM   = 3'd1;
   localparam logic [SEL_W-1:0] SRC_SHIFT = 3'd2;
   localparam logic [SEL_W-1:0] SRC_HI    = 3'd3;
   localparam logic [SEL_W-1:0] SRC_LO    = 3'd4;
   localparam logic [SEL_W-1:0] SRC_LUI   = 3'd5;
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, HOLD = 2'd2} state_e;
endpackage

// File: rtl/wd_writeback_arbiter_rr_pick.sv
// wd_writeback_arbiter_rr_pick: round-robin pick of one eligible source starting at ptr
// ports: elig (eligible sources), ptr (highest-priority index) -> onehot, idx, found
module wd_writeback_arbiter_rr_pick
   import wd_writeback_arbiter_pkg::*;
(
   input  logic [N_SRC-1:0] elig,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_SRC-1:0] onehot,
   output logic [SEL_W-1:0] idx,
   output logic             found
);
   logic [2*N_SRC-1:0] dbl;
   logic [N_SRC-1:0]   rot;
   logic [SEL_W-1:0]   idx_r;
   logic [SEL_W:0]     sum;
   always_comb begin
      dbl = {elig, elig};
      rot = dbl[ptr +: N_SRC];
      idx_r = '0;
      for (int i = N_SRC - 1; i >= 0; i--) if (rot[i]) idx_r = SEL_W'(i);
      found = |rot;
      sum = {1'b0, idx_r} + {1'b0, ptr};
      idx = (sum >= (SEL_W+1)'(N_SRC)) ? SEL_W'(sum - (SEL_W+1)'(N_SRC)) : sum[SEL_W-1:0];
      onehot = found ? N_SRC'(1) << idx : '0;
   end
endmodule

// File: rtl/wd_writeback_arbiter.sv
// wd_writeback_arbiter: round-robin scheduler of the register-file write port among six Mux_WD sources
// ports: clk, reset (async active-low), stall, req, req_reg -> gnt, wd_sel, reg_write, write_reg (registered), busy (comb)
module wd_writeback_arbiter
   import wd_writeback_arbiter_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic [N_SRC-1:0]       req,
   input  logic [N_SRC*REG_W-1:0] req_reg,
   output logic [N_SRC-1:0]       gnt,
   output logic [SEL_W-1:0]       wd_sel,
   output logic                   reg_write,
   output logic [REG_W-1:0]       write_reg,
   output logic                   busy
);
   state_e             state_q, state_d;
   logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d, wd_sel_q, wd_sel_d, pick_idx;
   logic [N_SRC-1:0]   gnt_q, gnt_d, elig, pick_oh;
   logic [REG_W-1:0]   write_reg_q, write_reg_d, pick_reg;
   logic               reg_write_q, reg_write_d, pick_found, grant;
   // the source currently granted still holds req high, so it is masked out
   assign elig = req & ~gnt_q;
   wd_writeback_arbiter_rr_pick u_pick (
      .elig   (elig),
      .ptr    (rr_ptr_q),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .found  (pick_found)
   );
   always_comb begin
      pick_reg = req_reg[pick_idx*REG_W +: REG_W];
      // unused encoding recovers to IDLE; stall overrides any pending request
      state_d = (state_q > HOLD) ? IDLE : stall ? HOLD : pick_found ? GRANT : IDLE;
      grant = state_d == GRANT;
      gnt_d = grant ? pick_oh : '0;
      wd_sel_d = grant ? pick_idx : wd_sel_q;
      // a $0 destination yields pick_reg=0, so write_reg is forced to 0 as well
      reg_write_d = grant && (pick_reg != '0);
      write_reg_d = grant ? pick_reg : write_reg_q;
      rr_ptr_d = grant ? ((pick_idx == SEL_W'(N_SRC - 1)) ? '0 : pick_idx + 1'b1) : rr_ptr_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         wd_sel_q    <= '0;
         reg_write_q <= 1'b0;
         write_reg_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         wd_sel_q    <= wd_sel_d;
         reg_write_q <= reg_write_d;
         write_reg_q <= write_reg_d;
      end
   end
   assign gnt       = gnt_q;
   assign wd_sel    = wd_sel_q;
   assign reg_write = reg_write_q;
   assign write_reg = write_reg_q;
   assign busy      = (|elig) | (|gnt_q);
endmodule

// File: tb/tb_wd_writeback_arbiter.sv
// tb_wd_writeback_arbiter: scoreboard bench driving directed request patterns into wd_writeback_arbiter
module tb_wd_writeback_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [5:0]  req;
   logic [29:0] req_reg;
   logic [5:0]  gnt;
   logic [2:0]  wd_sel;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic        busy;
   int          checks = 0;
   int          failures = 0;
   typedef struct packed {
      logic [5:0] gnt;
      logic [2:0] sel;
      logic       we;
      logic [4:0] wr;
   } exp_t;
   exp_t q[$];
   wd_writeback_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .req       (req),
      .req_reg   (req_reg),
      .gnt       (gnt),
      .wd_sel    (wd_sel),
      .reg_write (reg_write),
      .write_reg (write_reg),
      .busy      (busy)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_reg(input int i, input logic [4:0] v);
      req_reg[i*5 +: 5] = v;
   endtask
   task automatic push(input int k, input logic we, input logic [4:0] wr);
      exp_t e;
      e.gnt = 6'(1 << k);
      e.sel = 3'(k);
      e.we  = we;
      e.wr  = wr;
      q.push_back(e);
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (reset === 1'b1 && (gnt !== 6'd0 || reg_write !== 1'b0)) begin
         exp_t e;
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual gnt=%b sel=%0d we=%b wr=%0d required no grant", gnt, wd_sel, reg_write, write_reg);
         end else begin
            e = q.pop_front();
            if ({gnt, wd_sel, reg_write, write_reg} !== e) begin
               failures++;
               $display("FAIL sb_grant actual gnt=%b sel=%0d we=%b wr=%0d required gnt=%b sel=%0d we=%b wr=%0d",
                        gnt, wd_sel, reg_write, write_reg, e.gnt, e.sel, e.we, e.wr);
            end
         end
      end
   end
   initial begin
      reset = 1'b0;
      stall = 1'b0;
      req = 6'h3F;
      req_reg = '0;
      for (int i = 0; i < 6; i++) set_reg(i, 5'(10 + i));
      repeat (3) step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_we", 32'(reg_write), 32'd0);
      chk("rst_sel", 32'(wd_sel), 32'd0);
      chk("rst_wr", 32'(write_reg), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) push(i, 1'b1, 5'(10 + i));
      for (int i = 0; i < 6; i++) begin
         step();
         chk("fair_nogap", 32'(|gnt), 32'd1);
         req[i] = 1'b0;
      end
      step();
      chk("fair_idle_busy", 32'(busy), 32'd0);
      set_reg(2, 5'd9);
      req = 6'b000100;
      push(2, 1'b1, 5'd9);
      step();
      chk("single_busy", 32'(busy), 32'd1);
      req = 6'b0;
      step();
      chk("single_idle_gnt", 32'(gnt), 32'd0);
      chk("single_idle_busy", 32'(busy), 32'd0);
      chk("single_hold_sel", 32'(wd_sel), 32'd2);
      chk("single_hold_wr", 32'(write_reg), 32'd9);
      set_reg(4, 5'd20);
      req = 6'b010000;
      push(4, 1'b1, 5'd20);
      step();
      req = 6'b0;
      step();
      set_reg(5, 5'd21);
      set_reg(0, 5'd22);
      set_reg(1, 5'd23);
      req = 6'b100011;
      push(5, 1'b1, 5'd21);
      push(0, 1'b1, 5'd22);
      push(1, 1'b1, 5'd23);
      step();
      req[5] = 1'b0;
      step();
      req[0] = 1'b0;
      step();
      req[1] = 1'b0;
      step();
      chk("wrap_idle", 32'(gnt), 32'd0);
      stall = 1'b1;
      set_reg(3, 5'd7);
      req = 6'b001000;
      repeat (3) begin
         step();
         chk("stall_gnt", 32'(gnt), 32'd0);
         chk("stall_we", 32'(reg_write), 32'd0);
      end
      stall = 1'b0;
      push(3, 1'b1, 5'd7);
      step();
      req = 6'b0;
      step();
      set_reg(1, 5'd0);
      req = 6'b000010;
      push(1, 1'b0, 5'd0);
      step();
      req = 6'b0;
      step();
      set_reg(0, 5'd6);
      req = 6'b000001;
      push(0, 1'b1, 5'd6);
      step();
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("async_rst_gnt", 32'(gnt), 32'd0);
      chk("async_rst_we", 32'(reg_write), 32'd0);
      req = 6'b0;
      chk("sb_drain", 32'(q.size()), 32'd0);
      repeat (2) step();
      reset = 1'b1;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
